// File: rtl/dft_pkg.sv
// Shared constants and types for the DFT output serializer slice.
package dft_pkg;

  // Default frame geometry as produced by dft_top
  localparam int DFT_WIDTH = 32;
  localparam int DFT_NPTS  = 16;
  localparam int DFT_IDX_W = $clog2(DFT_NPTS);
  localparam int DFT_NBUF  = 2;

  // Streaming controller states: nothing to send, or a frame is being emitted
  typedef enum logic {
    IDLE,
    STREAM
  } dft_state_e;

endpackage

// File: rtl/dft_frame_buf.sv
// Ping-pong frame storage: NBUF frames of NPTS words, written a whole frame at a
// time, read back one word at a time.
module dft_frame_buf
  import dft_pkg::*;
#(
  parameter int WIDTH = DFT_WIDTH,
  parameter int NPTS  = DFT_NPTS,
  parameter int NBUF  = DFT_NBUF,
  parameter int PTR_W = 1,
  parameter int IDX_W = DFT_IDX_W
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [PTR_W-1:0]        wr_ptr,
  input  logic [WIDTH*NPTS-1:0]   wr_frame,
  input  logic [PTR_W-1:0]        rd_ptr,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [WIDTH-1:0]        rd_data
);

  logic [WIDTH-1:0] mem [NBUF][NPTS];

  // Store every word of the incoming frame into the selected buffer in one cycle
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NPTS; k++) begin
        mem[wr_ptr][k] <= wr_frame[k*WIDTH +: WIDTH];
      end
    end
  end

  assign rd_data = mem[rd_ptr][rd_idx];

endmodule

// File: rtl/dft_out_serializer.sv
// Captures complete dft_top output frames and streams them word by word on a
// valid/ready interface, using a small ring of frame buffers so a new frame can
// arrive while the previous one is still draining.
module dft_out_serializer
  import dft_pkg::*;
#(
  parameter int WIDTH = DFT_WIDTH,
  parameter int NPTS  = DFT_NPTS,
  parameter int NBUF  = DFT_NBUF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      next_out,
  input  logic [WIDTH*NPTS-1:0]     y_flat,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic [$clog2(NPTS)-1:0]   m_index,
  output logic                      m_last,
  output logic                      busy,
  output logic                      overflow
);

  localparam int IDX_W = $clog2(NPTS);
  localparam int PTR_W = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int CNT_W = $clog2(NBUF + 1);

  // Ring pointer advance; a single buffer always sits at slot 0
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (NBUF == 1) return '0;
    return (p == PTR_W'(NBUF - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  dft_state_e        state;
  logic              next_out_d;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_W-1:0]  full_cnt;
  logic [CNT_W-1:0]  full_cnt_n;
  logic              hs;
  logic              release_frame;
  logic              buf_free;
  logic              cap;
  logic              load_new;
  logic              bypass;
  logic [IDX_W-1:0]  rd_idx;
  logic [WIDTH-1:0]  buf_word;
  logic [WIDTH-1:0]  next_word;

  // Decide this cycle's capture/release and which word the output register loads next
  always_comb begin
    hs            = m_valid && m_ready;
    release_frame = hs && m_last;
    // A buffer freed by the final handshake of a frame can be refilled in the same cycle
    buf_free      = (full_cnt < CNT_W'(NBUF)) || release_frame;
    cap           = next_out_d && buf_free;
    full_cnt_n    = full_cnt + CNT_W'(cap) - CNT_W'(release_frame);
    rd_ptr_n      = release_frame ? ptr_inc(rd_ptr) : rd_ptr;
    load_new      = !m_valid || release_frame;
    rd_idx        = load_new ? '0 : m_index + IDX_W'(1);
    // The next frame to show may be the one being written right now: forward its word 0
    bypass        = load_new && cap && (wr_ptr == rd_ptr_n);
    next_word     = bypass ? y_flat[WIDTH-1:0] : buf_word;
  end

  dft_frame_buf #(
    .WIDTH (WIDTH),
    .NPTS  (NPTS),
    .NBUF  (NBUF),
    .PTR_W (PTR_W),
    .IDX_W (IDX_W)
  ) u_frame_buf (
    .clk      (clk),
    .wr_en    (cap),
    .wr_ptr   (wr_ptr),
    .wr_frame (y_flat),
    .rd_ptr   (rd_ptr_n),
    .rd_idx   (rd_idx),
    .rd_data  (buf_word)
  );

  // Frame bookkeeping: capture strobe delay, ring pointers, occupancy and sticky drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_out_d <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      full_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      next_out_d <= next_out;
      full_cnt   <= full_cnt_n;
      rd_ptr     <= rd_ptr_n;
      if (cap) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (next_out_d && !buf_free) begin
        overflow <= 1'b1;
      end
    end
  end

  // Output streaming FSM with registered valid/data/index/last
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_index <= '0;
      m_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (full_cnt_n != '0) begin
            state   <= STREAM;
            m_valid <= 1'b1;
            m_index <= '0;
            m_last  <= 1'b0;
            m_data  <= next_word;
          end
        end
        STREAM: begin
          if (m_ready) begin
            if (!m_last) begin
              m_index <= rd_idx;
              m_data  <= next_word;
              m_last  <= (rd_idx == IDX_W'(NPTS - 1));
            end else if (full_cnt_n != '0) begin
              m_index <= '0;
              m_data  <= next_word;
              m_last  <= 1'b0;
            end else begin
              state   <= IDLE;
              m_valid <= 1'b0;
              m_index <= '0;
              m_data  <= '0;
              m_last  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (full_cnt != '0);

endmodule

// File: tb/tb_dft_out_serializer.sv
// Self-checking bench for dft_out_serializer: directed vector table, multi-cycle
// corner sequences and randomized traffic checked against a queue-based model.
module tb_dft_out_serializer;

  localparam int W    = 32;
  localparam int N    = 16;
  localparam int NBUF = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             next_out = 1'b0;
  logic [W*N-1:0]   y_flat = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [W-1:0]     m_data;
  logic [3:0]       m_index;
  logic             m_last;
  logic             busy;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] data;
    int           idx;
  } word_t;

  word_t        model_q[$];
  bit           model_ovf = 0;
  bit           model_pend = 0;
  bit           mon_en = 0;
  logic [W-1:0] got_q[$];
  logic [W*N-1:0] next_y = '0;

  typedef struct {
    bit           pulse;
    bit           rdy;
    bit           exp_valid;
    logic [W-1:0] exp_data;
    int           exp_idx;
    bit           exp_last;
    bit           exp_busy;
  } vec_t;

  vec_t vecs[18];

  dft_out_serializer #(.WIDTH(W), .NPTS(N), .NBUF(NBUF)) dut (
    .clk      (clk),
    .reset    (reset),
    .next_out (next_out),
    .y_flat   (y_flat),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [W*N-1:0] make_frame(input logic [W-1:0] base);
    logic [W*N-1:0] f;
    f = '0;
    for (int k = 0; k < N; k++) f[k*W +: W] = base + W'(k);
    return f;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; frame data follows its next_out pulse by one cycle
  task automatic apply_stimulus(input bit pulse, input logic [W-1:0] base, input bit rdy);
    @(negedge clk);
    next_out = pulse;
    m_ready  = rdy;
    y_flat   = next_y;
    if (pulse) next_y = make_frame(base);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b0;
    next_out = 1'b0;
    m_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_q.delete();
  endtask

  task automatic expect_stream(input string name, input int base, input int n);
    check_output({name, "_len"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check_output({name, "_word"}, 64'(got_q[i]), 64'(base + i));
  endtask

  // Reference model: queue of words still to be delivered, frames counted by ceiling
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q.delete();
      model_ovf  = 0;
      model_pend = 0;
    end else begin
      int held;
      if (model_q.size() > 0 && m_ready) model_q.delete(0);
      if (model_pend) begin
        held = (model_q.size() + N - 1) / N;
        if (held < NBUF) begin
          for (int k = 0; k < N; k++) model_q.push_back('{y_flat[k*W +: W], k});
        end else begin
          model_ovf = 1;
        end
      end
      model_pend = next_out;
    end
  end

  // Record every accepted word
  always @(posedge clk) begin
    if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) got_q.push_back(m_data);
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en && reset) begin
      bit ev;
      ev = (model_q.size() > 0);
      check_output("mon_valid", 64'(m_valid), 64'(ev));
      if (ev) begin
        check_output("mon_data", 64'(m_data), 64'(model_q[0].data));
        check_output("mon_index", 64'(m_index), 64'(model_q[0].idx));
        check_output("mon_last", 64'(m_last), 64'(model_q[0].idx == N - 1));
      end
      check_output("mon_busy", 64'(busy), 64'(ev));
      check_output("mon_overflow", 64'(overflow), 64'(model_ovf));
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #1 reset = 1'b0;
    #1;
    check_output("rst_valid", 64'(m_valid), 0);
    check_output("rst_data", 64'(m_data), 0);
    check_output("rst_index", 64'(m_index), 0);
    check_output("rst_last", 64'(m_last), 0);
    check_output("rst_busy", 64'(busy), 0);
    check_output("rst_overflow", 64'(overflow), 0);
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    mon_en = 1;

    // Test 1: vector table for a single frame Yk=k with m_ready high
    vecs[0] = '{1'b1, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0};
    for (int r = 1; r <= 16; r++)
      vecs[r] = '{1'b0, 1'b1, 1'b1, W'(r - 1), r - 1, (r == 16), 1'b1};
    vecs[17] = '{1'b0, 1'b1, 1'b0, '0, 0, 1'b0, 1'b0};
    for (int r = 0; r < 18; r++) begin
      apply_stimulus(vecs[r].pulse, 0, vecs[r].rdy);
      @(posedge clk);
      #1;
      check_output("t1_valid", 64'(m_valid), 64'(vecs[r].exp_valid));
      if (vecs[r].exp_valid) begin
        check_output("t1_data", 64'(m_data), 64'(vecs[r].exp_data));
        check_output("t1_index", 64'(m_index), 64'(vecs[r].exp_idx));
        check_output("t1_last", 64'(m_last), 64'(vecs[r].exp_last));
      end
      check_output("t1_busy", 64'(busy), 64'(vecs[r].exp_busy));
    end

    // Test 2: backpressure pattern 1,0,0,1
    apply_reset();
    for (int i = 0; i < 90; i++) apply_stimulus(i == 0, 0, (i % 4 == 0) || (i % 4 == 3));
    expect_stream("t2", 0, 16);

    // Test 3: two back-to-back frames, no bubble
    apply_reset();
    for (int i = 0; i < 45; i++) apply_stimulus(i < 2, W'(i * 16), 1'b1);
    expect_stream("t3", 0, 32);
    check_output("t3_overflow", 64'(overflow), 0);

    // Test 4: three frames while stalled, third dropped
    apply_reset();
    for (int i = 0; i < 5; i++) apply_stimulus(i < 3, W'(i * 16), 1'b0);
    check_output("t4_overflow_set", 64'(overflow), 1);
    for (int i = 0; i < 60; i++) apply_stimulus(0, 0, 1'b1);
    expect_stream("t4", 0, 32);
    check_output("t4_overflow_sticky", 64'(overflow), 1);

    // Test 5: capture coincides with word-15 handshake while both buffers are full
    apply_reset();
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 16, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(0, 0, 0);
    check_output("t5_busy_full", 64'(busy), 1);
    for (int i = 0; i < 15; i++) apply_stimulus(i == 14, 32, 1'b1);
    for (int i = 0; i < 50; i++) apply_stimulus(0, 0, 1'b1);
    expect_stream("t5", 0, 48);
    check_output("t5_overflow", 64'(overflow), 0);

    // Test 6: asynchronous reset mid-frame, then a fresh frame
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      apply_stimulus(i == 0, 0, 1'b1);
      if (got_q.size() >= 8) break;
    end
    check_output("t6_reached_w7", 64'(got_q.size() >= 8), 1);
    #3 reset = 1'b0;
    #1;
    check_output("t6_valid", 64'(m_valid), 0);
    check_output("t6_data", 64'(m_data), 0);
    check_output("t6_index", 64'(m_index), 0);
    check_output("t6_last", 64'(m_last), 0);
    check_output("t6_busy", 64'(busy), 0);
    check_output("t6_overflow", 64'(overflow), 0);
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    next_out = 1'b0;
    got_q.delete();
    for (int i = 0; i < 25; i++) apply_stimulus(i == 0, 100, 1'b1);
    expect_stream("t6", 100, 16);

    // Randomized traffic checked by the model
    apply_reset();
    for (int i = 0; i < 1500; i++)
      apply_stimulus($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 100; i++) apply_stimulus(0, 0, 1'b1);
    check_output("rnd_drained", 64'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
